// File: rtl/ysyx_040066_mul_issue.sv
// ysyx_040066_mul_issue: valid/ready issue stage and stage tracking for the 2-stage multiplier
module ysyx_040066_mul_issue #(
  parameter int TAG_W = 5,
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [63:0]      in_src1,
  input  logic [63:0]      in_src2,
  input  logic [1:0]       in_op,
  input  logic             in_is_w,
  input  logic [TAG_W-1:0] in_tag,
  output logic [63:0]      mul_src1,
  output logic [63:0]      mul_src2,
  output logic [1:0]       mul_ctr_in,
  output logic [1:0]       mul_ctr,
  output logic             mul_is_w,
  output logic             mul_block,
  input  logic [63:0]      mul_result,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [63:0]      out_data,
  output logic [TAG_W-1:0] out_tag,
  output logic             busy,
  output logic [CNT_W-1:0] done_cnt
);
  logic             v1, v2, w1, hold;
  logic [1:0]       op1;
  logic [TAG_W-1:0] tag1, tag2;
  assign hold       = v2 & ~out_ready;
  assign mul_block  = hold;
  assign in_ready   = ~hold;
  assign mul_src1   = in_src1;
  assign mul_src2   = in_src2;
  assign mul_ctr_in = in_op;
  assign mul_ctr    = op1;
  assign mul_is_w   = w1;
  assign out_valid  = v2;
  assign out_data   = mul_result;
  assign out_tag    = tag2;
  assign busy       = v1 | v2;
  // W-forms only exist for the low product, so any other op is folded to MUL
  always_ff @(posedge clk) begin
    if (rst) begin
      v1   <= 1'b0;
      v2   <= 1'b0;
      op1  <= 2'b00;
      w1   <= 1'b0;
      tag1 <= '0;
      tag2 <= '0;
    end else if (flush) begin
      v1 <= 1'b0;
      v2 <= 1'b0;
    end else if (!hold) begin
      v1   <= in_valid;
      op1  <= in_is_w ? 2'b00 : in_op;
      w1   <= in_is_w;
      tag1 <= in_tag;
      v2   <= v1;
      tag2 <= tag1;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) done_cnt <= '0;
    else if (out_valid & out_ready & ~flush) done_cnt <= done_cnt + 1'b1;
  end
endmodule

// File: tb/tb_ysyx_040066_mul_issue.sv
// tb_ysyx_040066_mul_issue: random + directed check of the multiply issue stage against a queue model
module tb_ysyx_040066_mul_issue;
  logic        clk = 1'b0;
  logic        rst = 1'b1, flush = 1'b0, in_valid = 1'b0, in_is_w = 1'b0, out_ready = 1'b1;
  logic [63:0] in_src1 = '0, in_src2 = '0, mul_src1, mul_src2, mul_result, out_data;
  logic [1:0]  in_op = '0, mul_ctr_in, mul_ctr;
  logic [4:0]  in_tag = '0, out_tag;
  logic        in_ready, mul_is_w, mul_block, out_valid, busy;
  logic [31:0] done_cnt;
  ysyx_040066_mul_issue dut (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .in_src1(in_src1), .in_src2(in_src2), .in_op(in_op), .in_is_w(in_is_w), .in_tag(in_tag),
    .mul_src1(mul_src1), .mul_src2(mul_src2), .mul_ctr_in(mul_ctr_in), .mul_ctr(mul_ctr),
    .mul_is_w(mul_is_w), .mul_block(mul_block), .mul_result(mul_result),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_tag(out_tag),
    .busy(busy), .done_cnt(done_cnt)
  );
  always #5 clk = ~clk;
  function automatic logic [63:0] prod(input logic [63:0] a, input logic [63:0] b,
                                       input logic [1:0] op, input logic w);
    logic [127:0] sa, sb, p;
    logic [63:0]  r;
    sa = (op == 2'b01 || op == 2'b10) ? {{64{a[63]}}, a} : {64'b0, a};
    sb = (op == 2'b01) ? {{64{b[63]}}, b} : {64'b0, b};
    p  = sa * sb;
    r  = (op == 2'b00) ? p[63:0] : p[127:64];
    return w ? {{32{r[31]}}, r[31:0]} : r;
  endfunction
  // stand-in for the external multiplier: two frozen-by-block register stages
  logic [63:0] a1, b1, r2;
  always @(posedge clk)
    if (!mul_block) begin
      a1 <= mul_src1;
      b1 <= mul_src2;
      r2 <= prod(a1, b1, mul_ctr, mul_is_w);
    end
  assign mul_result = r2;
  typedef struct {logic [63:0] d; logic [4:0] t; int acc;} ent_t;
  ent_t q[$];
  int checks = 0, failures = 0, cyc = 0;
  int unsigned cnt = 0;
  logic prev_rst = 1'b0;
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h cycle=%0d", tag, got, exp, cyc);
    end
  endtask
  task automatic step(input logic r, input logic fl, input logic iv, input logic [63:0] a,
                      input logic [63:0] b, input logic [1:0] op, input logic w,
                      input logic [4:0] t, input logic ordy);
    logic ov, ir;
    rst = r; flush = fl; in_valid = iv; in_src1 = a; in_src2 = b;
    in_op = op; in_is_w = w; in_tag = t; out_ready = ordy;
    @(negedge clk);
    ov = q.size() > 0 && cyc >= q[0].acc + 2;
    ir = !(ov && !ordy);
    chk("out_valid", 64'(out_valid), 64'(ov));
    chk("in_ready", 64'(in_ready), 64'(ir));
    chk("mul_block", 64'(mul_block), 64'(!ir));
    chk("busy", 64'(busy), 64'(q.size() > 0));
    chk("done_cnt", 64'(done_cnt), 64'(cnt));
    chk("mul_src1", mul_src1, a);
    chk("mul_ctr_in", 64'(mul_ctr_in), 64'(op));
    if (ov) begin
      chk("out_data", out_data, q[0].d);
      chk("out_tag", 64'(out_tag), 64'(q[0].t));
    end
    if (prev_rst && !r) begin
      chk("rst_mul_ctr", 64'(mul_ctr), 64'd0);
      chk("rst_mul_is_w", 64'(mul_is_w), 64'd0);
      chk("rst_out_tag", 64'(out_tag), 64'd0);
    end
    if (r) begin
      q.delete();
      cnt = 0;
    end else if (fl) q.delete();
    else begin
      if (ov && ordy) begin
        void'(q.pop_front());
        cnt++;
      end
      if (iv && ir) q.push_back('{prod(a, b, w ? 2'b00 : op, w), t, cyc});
    end
    prev_rst = r;
    cyc++;
    @(posedge clk);
    #1;
  endtask
  task automatic op_in(input logic [63:0] a, input logic [63:0] b, input logic [1:0] op,
                       input logic w, input logic [4:0] t, input logic ordy);
    step(1'b0, 1'b0, 1'b1, a, b, op, w, t, ordy);
  endtask
  task automatic idle(input int n, input logic ordy);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, '0, '0, 2'b00, 1'b0, 5'd0, ordy);
  endtask
  initial begin
    @(posedge clk);
    #1;
    step(1'b1, 1'b0, 1'b0, '0, '0, 2'b00, 1'b0, 5'd0, 1'b1);
    idle(2, 1'b1);
    op_in(64'd3, 64'hFFFF_FFFF_FFFF_FFFB, 2'b00, 1'b0, 5'd7, 1'b1);
    op_in(64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 2'b01, 1'b0, 5'd8, 1'b1);
    op_in('1, '1, 2'b11, 1'b0, 5'd9, 1'b1);
    op_in('1, 64'd2, 2'b10, 1'b0, 5'd10, 1'b1);
    op_in(64'h7FFF_FFFF, 64'd2, 2'b00, 1'b1, 5'd11, 1'b1);
    op_in(64'h1234_5678_9ABC_DEF0, 64'hFFFF_FFFF_8000_0003, 2'b01, 1'b1, 5'd12, 1'b1);
    idle(3, 1'b1);
    op_in(64'd5, 64'd6, 2'b00, 1'b0, 5'd1, 1'b1);
    op_in(64'd7, 64'd8, 2'b00, 1'b0, 5'd2, 1'b1);
    for (int i = 0; i < 3; i++) op_in(64'd9, 64'd10, 2'b00, 1'b0, 5'd3, 1'b0);
    op_in(64'd9, 64'd10, 2'b00, 1'b0, 5'd3, 1'b1);
    idle(3, 1'b1);
    op_in(64'd11, 64'd12, 2'b11, 1'b0, 5'd4, 1'b1);
    op_in(64'd13, 64'd14, 2'b01, 1'b0, 5'd5, 1'b0);
    step(1'b0, 1'b1, 1'b1, 64'd15, 64'd16, 2'b00, 1'b0, 5'd6, 1'b0);
    idle(2, 1'b1);
    op_in(64'd17, 64'd18, 2'b00, 1'b0, 5'd13, 1'b0);
    op_in(64'd19, 64'd20, 2'b00, 1'b0, 5'd14, 1'b0);
    idle(2, 1'b0);
    step(1'b1, 1'b0, 1'b1, 64'd21, 64'd22, 2'b00, 1'b0, 5'd15, 1'b0);
    idle(2, 1'b1);
    for (int i = 0; i < 3000; i++) begin
      logic [63:0] a, b;
      a = {$urandom, $urandom};
      b = {$urandom, $urandom};
      if ($urandom_range(0, 3) == 0) a = 64'($signed(32'($urandom_range(0, 9)) - 32'sd5));
      step($urandom_range(0, 199) == 0, $urandom_range(0, 39) == 0, $urandom_range(0, 9) < 7,
           a, b, 2'($urandom_range(0, 3)), $urandom_range(0, 4) == 0,
           5'($urandom_range(0, 31)), $urandom_range(0, 9) < 7);
    end
    idle(4, 1'b1);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
